// File: rtl/trafficlight_ns_if.sv
// Light bus between the EW controller / intersection top and the NS signal-head controller.
// The master drives the EW lamp bus and the shared emergency line; the slave returns NS lamps and fault.
interface trafficlight_ns_if;
   logic       emergency;
   logic [3:0] ew_light;
   logic [3:0] out;
   logic       fault;

   modport master (output emergency, ew_light, input out, fault);
   modport slave  (input emergency, ew_light, output out, fault);
endinterface

// File: rtl/trafficlight_ns.sv
// NS signal-head controller: follows the EW lamp bus and runs one NS green sequence per EW red.
// A conflicting or illegal EW code latches a flashing-red fault that only reset clears.
module trafficlight_ns #(
   parameter int CLEAR_CYC  = 1,
   parameter int LEFT_CYC   = 4,
   parameter int GREEN_CYC  = 9,
   parameter int YELLOW_CYC = 3,
   parameter int FLASH_HALF = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   trafficlight_ns_if.slave  bus
);

   localparam logic [3:0] L_RED   = 4'b0001;
   localparam logic [3:0] L_LEFT  = 4'b1001;
   localparam logic [3:0] L_GREEN = 4'b0100;
   localparam logic [3:0] L_YEL   = 4'b0010;
   localparam logic [3:0] L_DARK  = 4'b0000;

   localparam logic [4:0] CLEAR_LAST  = 5'(CLEAR_CYC - 1);
   localparam logic [4:0] LEFT_LAST   = 5'(LEFT_CYC - 1);
   localparam logic [4:0] GREEN_LAST  = 5'(GREEN_CYC - 1);
   localparam logic [4:0] YELLOW_LAST = 5'(YELLOW_CYC - 1);
   localparam logic [4:0] FLASH_LAST  = 5'(FLASH_HALF - 1);

   typedef enum logic [2:0] {
      S_WAIT, S_CLEAR, S_LEFT, S_GREEN, S_YELLOW, S_ALLSTOP, S_FAULT
   } state_t;

   state_t     state;
   logic [4:0] cnt;
   logic [3:0] ew_prev;
   logic [3:0] out_q;
   logic       fault_q;

   logic legal, red_edge, conflict, phase_done;

   assign legal    = (bus.ew_light == L_RED)   || (bus.ew_light == L_LEFT) ||
                     (bus.ew_light == L_GREEN) || (bus.ew_light == L_YEL);
   assign red_edge = (bus.ew_light == L_RED) && (ew_prev != L_RED);
   // Once NS shows anything but red, EW must be solidly red.
   assign conflict = ((state == S_LEFT) || (state == S_GREEN) || (state == S_YELLOW)) &&
                     (bus.ew_light != L_RED);

   always_comb begin
      phase_done = 1'b0;
      case (state)
         S_CLEAR:  phase_done = (cnt == CLEAR_LAST);
         S_LEFT:   phase_done = (cnt == LEFT_LAST);
         S_GREEN:  phase_done = (cnt == GREEN_LAST);
         S_YELLOW: phase_done = (cnt == YELLOW_LAST);
         default:  phase_done = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_WAIT;
         cnt     <= 5'd0;
         ew_prev <= L_RED;   // no start in the middle of an EW red already in progress
         out_q   <= L_RED;
         fault_q <= 1'b0;
      end else begin
         ew_prev <= bus.ew_light;
         if (state == S_FAULT) begin
            if (cnt == FLASH_LAST) begin
               cnt   <= 5'd0;
               out_q <= (out_q == L_RED) ? L_DARK : L_RED;
            end else begin
               cnt <= cnt + 5'd1;
            end
         end else if (!legal || conflict) begin
            state   <= S_FAULT;
            fault_q <= 1'b1;
            out_q   <= L_RED;
            cnt     <= 5'd0;
         end else if (bus.emergency) begin
            state <= S_ALLSTOP;
            out_q <= L_RED;
            cnt   <= 5'd0;
         end else begin
            case (state)
               S_WAIT: begin
                  if (red_edge) begin
                     state <= S_CLEAR;
                     out_q <= L_RED;
                     cnt   <= 5'd0;
                  end
               end
               S_CLEAR: begin
                  if (phase_done) begin
                     state <= S_LEFT;
                     out_q <= L_LEFT;
                     cnt   <= 5'd0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
               S_LEFT: begin
                  if (phase_done) begin
                     state <= S_GREEN;
                     out_q <= L_GREEN;
                     cnt   <= 5'd0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
               S_GREEN: begin
                  if (phase_done) begin
                     state <= S_YELLOW;
                     out_q <= L_YEL;
                     cnt   <= 5'd0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
               S_YELLOW: begin
                  if (phase_done) begin
                     state <= S_WAIT;
                     out_q <= L_RED;
                     cnt   <= 5'd0;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end
               // Emergency released: back to WAIT, a fresh EW red edge is required.
               S_ALLSTOP: begin
                  state <= S_WAIT;
                  out_q <= L_RED;
                  cnt   <= 5'd0;
               end
               default: begin
                  state <= S_WAIT;
                  out_q <= L_RED;
                  cnt   <= 5'd0;
               end
            endcase
         end
      end
   end

   assign bus.out   = out_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_trafficlight_ns.sv
// Scoreboard bench for trafficlight_ns: the driver queues hand-derived lamp/fault values per edge,
// a monitor pops and compares them one cycle at a time.
module tb_trafficlight_ns;

   localparam logic [3:0] R = 4'b0001;
   localparam logic [3:0] L = 4'b1001;
   localparam logic [3:0] G = 4'b0100;
   localparam logic [3:0] Y = 4'b0010;
   localparam logic [3:0] D = 4'b0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   trafficlight_ns_if bus();

   trafficlight_ns dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [4:0] exp_q[$];
   string      nm_q[$];
   int         n_chk  = 0;
   int         n_fail = 0;

   // EW lamp code at position i of an EW cycle: red x18, left x5, green x10, yellow x3.
   function automatic logic [3:0] ew_at(input int i);
      if (i < 18)      return R;
      else if (i < 23) return L;
      else if (i < 33) return G;
      else             return Y;
   endfunction

   // NS lamps i cycles after a sampled EW red edge, default timing.
   function automatic logic [3:0] seq_exp(input int i);
      if (i >= 1 && i <= 4)       return L;
      else if (i >= 5 && i <= 13) return G;
      else if (i >= 14 && i <= 16) return Y;
      else                        return R;
   endfunction

   // Fault flash m cycles after the fault edge, half-period 2.
   function automatic logic [3:0] flash(input int m);
      return (((m / 2) % 2) == 0) ? R : D;
   endfunction

   task automatic cyc(input logic [3:0] ew, input logic em, input logic rn,
                      input logic [3:0] eo, input logic ef, input string nm);
      @(negedge clk);
      bus.ew_light  = ew;
      bus.emergency = em;
      rst_n         = rn;
      exp_q.push_back({ef, eo});
      nm_q.push_back(nm);
   endtask

   initial begin : monitor
      logic [4:0] e;
      string      n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            n_chk++;
            if ({bus.fault, bus.out} !== e) begin
               n_fail++;
               $display("FAIL %s: got out=%b fault=%b, required out=%b fault=%b",
                        n, bus.out, bus.fault, e[3:0], e[4]);
            end
         end
      end
   end

   initial begin : stim
      int waited;
      bus.ew_light  = R;
      bus.emergency = 1'b0;
      rst_n         = 1'b0;

      cyc(R, 0, 0, R, 0, "reset");
      cyc(R, 0, 0, R, 0, "reset_hold");

      for (int i = 0; i < 36; i++) cyc(ew_at(i), 0, 1, R, 0, "first_red_no_move");
      for (int i = 0; i < 36; i++) cyc(ew_at(i), 0, 1, seq_exp(i), 0, "second_red_seq");

      // Conflict: EW green while NS is green.
      for (int i = 0; i < 7; i++) cyc(ew_at(i), 0, 1, seq_exp(i), 0, "pre_conflict");
      cyc(G, 0, 1, R, 1, "conflict_edge");
      for (int m = 1; m <= 10; m++) cyc(G, (m % 3) == 0, 1, flash(m), 1, "conflict_flash");
      cyc(R, 0, 0, R, 0, "reset_clears_fault");

      // Illegal code while waiting.
      cyc(R, 0, 1, R, 0, "wait_legal");
      cyc(4'b0110, 0, 1, R, 1, "illegal_edge");
      for (int m = 1; m <= 4; m++) cyc(R, 1, 1, flash(m), 1, "illegal_flash");
      cyc(R, 0, 0, R, 0, "reset2");

      // Emergency during protected left.
      cyc(Y, 0, 1, R, 0, "pre_edge");
      cyc(R, 0, 1, R, 0, "edge_clear");
      cyc(R, 0, 1, L, 0, "left1");
      cyc(R, 0, 1, L, 0, "left2");
      for (int i = 0; i < 3; i++) cyc(R, 1, 1, R, 0, "emerg_allstop");
      for (int i = 0; i < 20; i++) cyc(R, 0, 1, R, 0, "no_restart");
      cyc(Y, 0, 1, R, 0, "pre_edge2");
      cyc(R, 0, 1, R, 0, "edge2_clear");
      cyc(R, 0, 1, L, 0, "restart_left");
      cyc(R, 0, 0, R, 0, "reset3");

      // Emergency coincident with the EW red edge.
      cyc(Y, 0, 1, R, 0, "pre_edge3");
      cyc(R, 1, 1, R, 0, "emerg_on_edge");
      for (int i = 1; i <= 17; i++) cyc(R, 0, 1, R, 0, "emerg_red_stays");
      cyc(L, 0, 1, R, 0, "ew_left_wait");
      cyc(L, 0, 1, R, 0, "ew_left_wait2");

      // Reset pulse during NS green.
      cyc(Y, 0, 1, R, 0, "pre_edge4");
      for (int i = 0; i < 8; i++) cyc(R, 0, 1, seq_exp(i), 0, "to_green");
      cyc(R, 0, 0, R, 0, "reset_in_green");
      for (int i = 0; i < 10; i++) cyc(R, 0, 1, R, 0, "post_reset_wait");
      cyc(Y, 0, 1, R, 0, "pre_edge5");
      cyc(R, 0, 1, R, 0, "edge5_clear");
      cyc(R, 0, 1, L, 0, "edge5_left");

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         #2;
         waited++;
      end
      if (exp_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
